// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with the carry held in a register between chunks. start/busy/done handshake.
module addsub_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             a_ns_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NCH - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("addsub_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_k, b_k, sum_k;
    logic             c_out_k, c_msb_k;
    logic [WIDTH-1:0] merged;

    // Current chunk slice and its sum; subtract feeds ~b with cin=1 from IDLE.
    always_comb begin
        base               = 32'(k_q) * CHUNK;
        a_k                = CHUNK'(a_q >> base);
        b_k                = mode_q ? CHUNK'(b_q >> base) : ~CHUNK'(b_q >> base);
        {c_out_k, sum_k}   = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit of this chunk, recovered from its sum bit.
        c_msb_k            = a_k[CHUNK-1] ^ b_k[CHUNK-1] ^ sum_k[CHUNK-1];
        merged             = (part_q & ~(WIDTH'({CHUNK{1'b1}}) << base))
                           | (WIDTH'(sum_k) << base);
    end

    // Next-state logic for the IDLE/RUN sequencer and the datapath registers.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        k_d     = k_q;
        part_d  = part_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    mode_d  = a_ns_i;
                    carry_d = ~a_ns_i;
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                part_d  = merged;
                carry_d = c_out_k;
                k_d     = k_q + 1'b1;
                if (k_q == KLAST) begin
                    s_d     = merged;
                    cout_d  = c_out_k;
                    ovf_d   = c_msb_k ^ c_out_k;
                    done_d  = 1'b1;
                    k_d     = '0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State registers; an asynchronous reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            part_q  <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            part_q  <= part_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == ST_RUN);
    assign done_o = done_q;
    assign s_o    = s_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised multi-cycle add/subtract unit. It extends the 1-bit full adder/subtractor (a_ns mode select) to WIDTH-bit operands.
- Processes CHUNK bits per clock, LSB chunk first, through a registered carry chain.
- Uses a start/busy/done handshake.
- Used where a full-width single-cycle carry chain is too slow or too large. Register-file and ALU datapaths feed it operands and consume its registered result.

Parameters:
WIDTH, 32, operand/result width in bits; >= 1
CHUNK, 8, bits processed per cycle; 1 <= CHUNK <= WIDTH; WIDTH % CHUNK == 0 (elaboration error otherwise)
NCH (localparam), WIDTH/CHUNK, number of chunk cycles

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when not busy
a  in  WIDTH  operand A; sampled with start
b  in  WIDTH  operand B; sampled with start
a_ns  in  1  mode: 1 = add (a+b), 0 = subtract (a-b); sampled with start
busy  out  1  operation in progress
done  out  1  one-cycle pulse; s/cout/ovf valid from this cycle
s  out  WIDTH  result, modulo 2^WIDTH
cout  out  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned)
ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, done=0, s=0, cout=0, ovf=0; internal operand, carry and chunk-counter registers cleared.
- Reset deasserted mid-operation: the operation is abandoned and not resumed. The next start begins fresh.
- States:
  - IDLE: busy=0. On an edge with start=1: latch a, b, a_ns. Set carry = ~a_ns (subtract uses cin=1). Set chunk counter = 0. Go to RUN. busy=1 from the next cycle.
  - RUN: each edge processes chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK).
    - Computes a_k + (a_ns ? b_k : ~b_k) + carry.
    - Writes the sum chunk into the partial-result register and updates carry.
    - Increments k.
  - On the edge processing chunk NCH-1:
    - s <= full result; cout <= final carry.
    - ovf <= carry into MSB XOR carry out of MSB.
    - done <= 1 for exactly one cycle; busy <= 0; return to IDLE.
- Latency: start sampled at edge E0; done=1 and results visible after edge E_NCH, i.e. NCH cycles after the start edge.
  - WIDTH=32, CHUNK=8: 4 cycles.
  - CHUNK=WIDTH: 1 cycle.
- Outputs s/cout/ovf hold their values until the next completing operation. They are unchanged while RUN is in progress; the partial result is held internally.
- start while busy=1: ignored. No queuing, no effect on the current operation.
- start in the done cycle (state IDLE): accepted. Back-to-back throughput is one result per NCH+1 cycles; done is not asserted continuously.
- Operand inputs may change after the start edge without affecting the current result.
- Subtract: s = a + ~b + 1 mod 2^WIDTH. cout = ~borrow. ovf follows signed a-b overflow rules.
- Functional equivalence: WIDTH=1, CHUNK=1 must reproduce the 1-bit full adder/subtractor truth table for s and cout, with cin implied by a_ns.

Test Plan:
- WIDTH=32, CHUNK=8: start with a=5, b=3, a_ns=1 -> done exactly 4 cycles later; s=0x00000008, cout=0, ovf=0; busy=1 for the 4 intervening cycles.
- Subtract: 5-3 -> s=0x00000002, cout=1, ovf=0. Subtract: 3-5 -> s=0xFFFFFFFE, cout=0, ovf=0.
- Carry and overflow edge cases:
  - Chunk-boundary carry: 0x000000FF+0x00000001 -> s=0x00000100.
  - Full ripple: 0xFFFFFFFF+1 -> s=0, cout=1, ovf=0.
  - Signed overflow: 0x7FFFFFFF+1 -> s=0x80000000, ovf=1, cout=0.
  - Subtract overflow: 0x80000000-1 -> s=0x7FFFFFFF, ovf=1.
- Handshake:
  - Assert start with different operands 2 cycles into RUN -> ignored; result matches the first operation.
  - Assert start in the done cycle -> second operation accepted; its done follows 4 cycles later.
  - Change a/b the cycle after start -> result unaffected.
- Reset: pull rst_n low for one cycle mid-RUN (after 2 chunks) -> busy, done, s, cout, ovf all 0 immediately (asynchronously). No done pulse follows. The next start (6+2=8) completes correctly.
- Parameter sweep:
  - WIDTH=1, CHUNK=1: all 8 combinations of {a, b, a_ns} -> s/cout equal the full adder/subtractor truth table; 1-cycle latency.
  - WIDTH=16, CHUNK=16: random add/subtract results match a reference model; 1-cycle latency.
